// File: rtl/nios_core_led_out_if.sv
// nios_core_led_out_if: Avalon-MM slave bus bundle for the LED output port
// Ports (signals): address[2:0] word select, chipselect, write_n (active-low strobe),
//                  writedata[31:0], readdata[31:0] (registered, from slave)
interface nios_core_led_out_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    modport master (output address, chipselect, write_n, writedata, input readdata);
    modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/nios_core_led_out.sv
// nios_core_led_out: Avalon-MM LED output port with set/clear aliases and prescaled blink mask
// Ports: clk system clock; reset_n async active-low reset; bus Avalon-MM slave
//        (address, chipselect, write_n, writedata, readdata); out_port[WIDTH-1:0] LED drive
module nios_core_led_out #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter logic [23:0]      DIV_RESET   = 24'd2500000
) (
    input  logic              clk,
    input  logic              reset_n,
    nios_core_led_out_if.slave bus,
    output logic [WIDTH-1:0]  out_port
);
    logic [WIDTH-1:0] data;
    logic [WIDTH-1:0] blink_en;
    logic [23:0]      divider;
    logic [23:0]      cnt;
    logic             phase;
    logic [31:0]      rd_mux;
    logic             wr;
    logic             div_wr;
    logic [WIDTH-1:0] wd;

    assign wr     = bus.chipselect & ~bus.write_n;
    assign div_wr = wr && (bus.address == 3'd2);
    assign wd     = bus.writedata[WIDTH-1:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data     <= RESET_VALUE;
            blink_en <= '0;
            divider  <= DIV_RESET;
        end else if (wr) begin
            case (bus.address)
                3'd0:    data     <= wd;
                3'd1:    blink_en <= wd;
                3'd2:    divider  <= bus.writedata[23:0];
                3'd4:    data     <= data | wd;
                3'd5:    data     <= data & ~wd;
                default: ;
            endcase
        end
    end

    // A DIVIDER write reloads the counter and suppresses any toggle due on the same edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt   <= DIV_RESET;
            phase <= 1'b1;
        end else if (div_wr) begin
            cnt   <= bus.writedata[23:0];
        end else if (divider == 24'd0) begin
            cnt   <= 24'd0;
            phase <= 1'b1;
        end else if (cnt == 24'd0) begin
            cnt   <= divider;
            phase <= ~phase;
        end else begin
            cnt   <= cnt - 24'd1;
        end
    end

    always_comb begin
        rd_mux = '0;
        case (bus.address)
            3'd0:    rd_mux = 32'(data);
            3'd1:    rd_mux = 32'(blink_en);
            3'd2:    rd_mux = {8'd0, divider};
            3'd3:    rd_mux = {31'd0, phase};
            default: rd_mux = '0;
        endcase
    end

    // Read data is captured every cycle regardless of chipselect.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) bus.readdata <= '0;
        else          bus.readdata <= rd_mux;
    end

    assign out_port = data & ~(blink_en & {WIDTH{~phase}});
endmodule

// File: tb/tb_nios_core_led_out.sv
// tb_nios_core_led_out: scoreboard bench for the LED output port
module tb_nios_core_led_out;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] out_port;
    int         errs = 0;
    int         checks = 0;
    bit         prev_ph;

    localparam logic [31:0] DIVR = 32'd2500000;

    typedef struct {
        string       tag;
        bit          is_out;
        logic [31:0] exp;
    } exp_t;
    exp_t q[$];

    nios_core_led_out_if bus_if();

    nios_core_led_out #(.WIDTH(8), .RESET_VALUE(8'hA5), .DIV_RESET(24'd2500000)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus_if),
        .out_port(out_port)
    );

    always #5 clk = ~clk;

    task chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task drive(input logic cs, input logic wn, input logic [2:0] a, input logic [31:0] d);
        bus_if.chipselect = cs;
        bus_if.write_n    = wn;
        bus_if.address    = a;
        bus_if.writedata  = d;
    endtask

    task push(input string tag, input bit is_out, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.is_out = is_out;
        e.exp = exp;
        q.push_back(e);
    endtask

    task cyc;
        exp_t e;
        @(posedge clk);
        #1;
        while (q.size() > 0) begin
            e = q.pop_front();
            chk(e.tag, e.is_out ? {24'd0, out_port} : bus_if.readdata, e.exp);
        end
    endtask

    // One clock: expect out_port after the edge; optionally expect STATUS captured at the edge.
    task tick(input string tag, input logic [7:0] exp_o, input bit ph, input bit st);
        push(tag, 1'b1, {24'd0, exp_o});
        if (st) push({tag, "_st"}, 1'b0, {31'd0, prev_ph});
        cyc();
        prev_ph = ph;
    endtask

    task wr(input string tag, input logic [2:0] a, input logic [31:0] d, input logic [7:0] exp_o, input bit ph);
        drive(1'b1, 1'b0, a, d);
        tick(tag, exp_o, ph, 1'b0);
        drive(1'b0, 1'b1, 3'd3, 32'd0);
    endtask

    task rd(input string tag, input logic [2:0] a, input logic [31:0] exp);
        drive(1'b0, 1'b1, a, 32'd0);
        push(tag, 1'b0, exp);
        cyc();
    endtask

    function automatic logic [7:0] bl(input bit ph);
        return ph ? 8'h81 : 8'h80;
    endfunction

    initial begin
        drive(1'b0, 1'b1, 3'd0, 32'd0);
        prev_ph = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        wr("pre_data", 3'd0, 32'h12, 8'h12, 1'b1);
        wr("pre_blink", 3'd1, 32'hFF, 8'h12, 1'b1);
        wr("pre_div", 3'd2, 32'd7, 8'h12, 1'b1);
        repeat (3) tick("pre_run", 8'h12, 1'b1, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_out", {24'd0, out_port}, 32'hA5);
        chk("rst_rd", bus_if.readdata, 32'd0);
        @(posedge clk);
        #1;
        chk("rst_out_hold", {24'd0, out_port}, 32'hA5);
        chk("rst_rd_hold", bus_if.readdata, 32'd0);
        #2 reset_n = 1'b1;
        rd("rst_data", 3'd0, 32'hA5);
        rd("rst_blink", 3'd1, 32'd0);
        rd("rst_div", 3'd2, DIVR);
        rd("rst_status", 3'd3, 32'd1);

        wr("wr_data", 3'd0, 32'hFFFFFF0F, 8'h0F, 1'b1);
        wr("outset", 3'd4, 32'hFFFFFFF0, 8'hFF, 1'b1);
        wr("outclr", 3'd5, 32'hFFFFFF3C, 8'hC3, 1'b1);
        rd("rd_data", 3'd0, 32'hC3);

        wr("bl_en", 3'd1, 32'h01, 8'hC3, 1'b1);
        wr("bl_data", 3'd0, 32'h81, 8'h81, 1'b1);
        wr("bl_div", 3'd2, 32'd3, 8'h81, 1'b1);
        for (int i = 1; i <= 21; i++)
            tick("blink", bl(((i / 4) % 2) == 0), ((i / 4) % 2) == 0, 1'b1);

        wr("div0", 3'd2, 32'd0, 8'h80, 1'b0);
        repeat (5) tick("div0_run", 8'h81, 1'b1, 1'b1);

        wr("div2", 3'd2, 32'd2, 8'h81, 1'b1);
        for (int j = 1; j <= 8; j++)
            tick("div2_run", bl(j < 3 || j >= 6), j < 3 || j >= 6, 1'b1);

        wr("div5_tc", 3'd2, 32'd5, 8'h81, 1'b1);
        for (int k = 1; k <= 6; k++)
            tick("div5_run", bl(k < 6), k < 6, 1'b1);

        wr("bl_off", 3'd1, 32'd0, 8'h81, 1'b0);
        wr("rsv6", 3'd6, 32'hFF, 8'h81, 1'b0);
        wr("rsv7", 3'd7, 32'hFF, 8'h81, 1'b0);
        rd("rd4", 3'd4, 32'd0);
        rd("rd5", 3'd5, 32'd0);
        rd("rd6", 3'd6, 32'd0);
        rd("rd7", 3'd7, 32'd0);
        rd("rsv_data", 3'd0, 32'h81);
        rd("rsv_blink", 3'd1, 32'd0);
        rd("rsv_div", 3'd2, 32'd5);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/nios_core_led_out.md
Name: nios_core_led_out

Overview:
- Avalon-MM slave output port: the write-side counterpart of the switch input port. It drives board LEDs from the Nios II core.
- Holds an output data register with atomic set/clear aliases, plus a per-bit blink mask.
- A shared prescaler gates blink-enabled bits on and off at a software-programmable rate.
- Sits on the system interconnect beside the input ports; out_port goes straight to LED pins.

Parameters:
- WIDTH, 8, number of output bits (1..32).
- RESET_VALUE, 0, reset value of DATA[WIDTH-1:0].
- DIV_RESET, 2500000, reset value of the 24-bit DIVIDER register.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- address  in  3  register word select.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe; a write occurs when chipselect=1 and write_n=0.
- writedata  in  32  write data.
- readdata  out  32  registered read data.
- out_port  out  WIDTH  LED drive.

Behaviour:
- Reset is asynchronous on reset_n low. One clock domain; reset_n=0 is asserted and removed asynchronously. Reset values:
  - DATA=RESET_VALUE, BLINK_EN=0, DIVIDER=DIV_RESET.
  - cnt=DIV_RESET, phase=1, readdata=0.
  - out_port=RESET_VALUE[WIDTH-1:0].
- Register map (word addresses):
  - 0 DATA, R/W.
  - 1 BLINK_EN, R/W.
  - 2 DIVIDER, R/W, bits[23:0].
  - 3 STATUS, RO: bit0=phase.
  - 4 OUTSET, WO: DATA <= DATA | wd.
  - 5 OUTCLEAR, WO: DATA <= DATA & ~wd.
  - 6-7 reserved: writes ignored, read 0. Reads of 4/5 return 0.
- Write widths: only writedata[WIDTH-1:0] is used for DATA, BLINK_EN, OUTSET and OUTCLEAR; only [23:0] for DIVIDER. Upper bits are ignored.
- A write takes effect at the clock edge where the strobe is sampled.
- readdata is updated every clock, zero-extended, from a mux on address. This is independent of chipselect, giving a read latency of 1 cycle.
- Prescaler:
  - If DIVIDER==0: cnt is held at 0 and phase is forced to 1.
  - Else if cnt==0: cnt <= DIVIDER and phase toggles.
  - Else: cnt decrements.
  - Result: phase period = 2*(DIVIDER+1) cycles.
- A write to DIVIDER loads cnt with the new value on the same edge and leaves phase unchanged. This write overrides a coincident terminal count, so no toggle occurs on that edge.
- out_port = DATA & ~(BLINK_EN & {WIDTH{~phase}}). It is driven only from flops, with no combinational path from bus inputs. A write is therefore visible on out_port in the cycle after the write edge.
- A DATA/OUTSET/OUTCLEAR write coincident with a phase toggle: both take effect, since they are independent.
- Reset asserted mid-count returns all state to reset values immediately; the prescaler restarts from DIV_RESET.
- Only one bus write can occur per cycle, so register-to-register write conflicts cannot occur.

Test Plan:
- Reset check, WIDTH=8, RESET_VALUE=8'hA5:
  - Stimulus: pulse reset_n low mid-run, then read addresses 0-3.
  - Required: out_port=8'hA5 during reset; reads return 0xA5, 0, DIV_RESET, 1; readdata=0 while in reset.
- Set/clear and read latency:
  - Stimulus: write DATA=0x0F, OUTSET=0xF0, OUTCLEAR=0x3C, then read DATA.
  - Required: out_port goes 0x0F -> 0xFF -> 0xC3; read of DATA returns 0xC3 one cycle after address is presented; writedata[31:8]=all ones has no effect.
- Blink timing:
  - Stimulus: DIVIDER=3, BLINK_EN=0x01, DATA=0x81.
  - Required: out_port[0] alternates 4 cycles on, 4 cycles off; out_port[7] stays steady at 1; STATUS bit0 tracks phase.
- DIVIDER=0 disables blinking:
  - Stimulus: while blinking with phase=0, write DIVIDER=0.
  - Required: phase=1 on the next cycle and blink bits steady on; writing DIVIDER=2 then resumes with the first toggle 3 cycles later.
- DIVIDER write coincident with terminal count:
  - Stimulus: write DIVIDER=5 on the edge where cnt==0.
  - Required: no toggle on that edge; the next toggle occurs 6 cycles later.
- Reserved and write-only addresses:
  - Stimulus: write 0xFF to addresses 6 and 7; read addresses 4-7.
  - Required: state unchanged; all reads return 0.
